// File: rtl/calc_seq_ctrl_if.sv
// Command/response handshake bundle for calc_seq_ctrl.
// The cmd_chain signal exists only when CALC_SEQ_CHAIN_EN is defined.
interface calc_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_cin;
`ifdef CALC_SEQ_CHAIN_EN
    logic       cmd_chain;
`endif
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_op;
    logic [7:0] rsp_result;
    logic       rsp_flag;
    logic       rsp_err;

    modport slave (
`ifdef CALC_SEQ_CHAIN_EN
        input  cmd_chain,
`endif
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready,
        output cmd_ready, rsp_valid, rsp_op, rsp_result, rsp_flag, rsp_err
    );

    modport master (
`ifdef CALC_SEQ_CHAIN_EN
        output cmd_chain,
`endif
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_op, rsp_result, rsp_flag, rsp_err
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the 4-bit add/sub/mul calculator datapath.
// Optional operand chaining from the last good result: CALC_SEQ_CHAIN_EN.
//   state | meaning
//   IDLE  | calculator parked (mode 11), ready for a command
//   DRIVE | operands held on calculator for the settle window
//   RESP  | registered response presented, waiting for rsp_ready
module calc_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    calc_seq_ctrl_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       calc_mode,
    output logic [3:0]       calc_a,
    output logic [3:0]       calc_b,
    output logic             calc_c,
    input  logic             calc_addon,
    input  logic             calc_subon,
    input  logic             calc_mulon,
    input  logic [3:0]       calc_sum,
    input  logic [3:0]       calc_diff,
    input  logic             calc_carry,
    input  logic             calc_sgn,
    input  logic [7:0]       calc_pro
);
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t           state, state_nx;
    logic [1:0]       op_q;
    logic [3:0]       a_q, b_q, cnt_q, a_sel;
    logic             cin_q;
    logic [1:0]       rsp_op_q;
    logic [7:0]       rsp_result_q, cap_result;
    logic             rsp_flag_q, rsp_err_q, cap_flag, cap_err;
    logic [CNT_W-1:0] op_count_q;
    logic             accept, capture, rsp_done, cmd_ready_c, rsp_valid_c;

`ifdef CALC_SEQ_CHAIN_EN
    logic [3:0] last_res_q;
    assign a_sel = bus.cmd_chain ? last_res_q : bus.cmd_a;
`else
    assign a_sel = bus.cmd_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        capture     = 1'b0;
        rsp_done    = 1'b0;
        cmd_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        calc_mode   = 2'b11;
        calc_a      = 4'd0;
        calc_b      = 4'd0;
        calc_c      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = (bus.cmd_op == 2'b11) ? RESP : DRIVE;
                end
            end
            DRIVE: begin
                calc_mode = op_q;
                calc_a    = a_q;
                calc_b    = b_q;
                calc_c    = (op_q == 2'b00) & cin_q;
                if (cnt_q == 4'd1) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    rsp_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A unit-enable mismatch still captures the result, only err is raised.
    always_comb begin
        cap_result = 8'd0;
        cap_flag   = 1'b0;
        cap_err    = 1'b1;
        case (op_q)
            2'b00: begin
                cap_result = {4'b0, calc_sum};
                cap_flag   = calc_carry;
                cap_err    = !calc_addon | calc_subon | calc_mulon;
            end
            2'b01: begin
                cap_result = {4'b0, calc_diff};
                cap_flag   = calc_sgn;
                cap_err    = !calc_subon | calc_addon | calc_mulon;
            end
            2'b10: begin
                cap_result = calc_pro;
                cap_err    = !calc_mulon | calc_addon | calc_subon;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= 2'b00;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            cin_q        <= 1'b0;
            cnt_q        <= 4'd0;
            rsp_op_q     <= 2'b00;
            rsp_result_q <= 8'd0;
            rsp_flag_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.cmd_op;
                a_q   <= a_sel;
                b_q   <= bus.cmd_b;
                cin_q <= bus.cmd_cin;
                cnt_q <= 4'(SETTLE_CYCLES);
                if (bus.cmd_op == 2'b11) begin
                    rsp_op_q     <= 2'b11;
                    rsp_result_q <= 8'd0;
                    rsp_flag_q   <= 1'b0;
                    rsp_err_q    <= 1'b1;
                end
            end else if (state == DRIVE) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                rsp_op_q     <= op_q;
                rsp_result_q <= cap_result;
                rsp_flag_q   <= cap_flag;
                rsp_err_q    <= cap_err;
            end
            if (rsp_done && !rsp_err_q)
                op_count_q <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef CALC_SEQ_CHAIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      last_res_q <= 4'd0;
        else if (rsp_done && !rsp_err_q) last_res_q <= rsp_result_q[3:0];
    end
`endif

    assign bus.cmd_ready  = cmd_ready_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flag   = rsp_flag_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = (state != IDLE);
    assign op_count       = op_count_q;
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed, table-driven bench for calc_seq_ctrl with a behavioural calculator model.
// Exercises SETTLE_CYCLES=1 and 4 instances; chaining is covered when CALC_SEQ_CHAIN_EN is defined.
module tb_calc_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic kill_mulon = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic       addon, subon, mulon;
        logic [3:0] sum;
        logic       carry;
        logic [3:0] diff;
        logic       sgn;
        logic [7:0] pro;
    } calc_t;

    function automatic calc_t calc_model(logic [1:0] m, logic [3:0] a, logic [3:0] b, logic c);
        calc_t    r;
        logic [4:0] s;
        r = '0;
        case (m)
            2'b00: begin
                r.addon = 1'b1;
                s = {1'b0, a} + {1'b0, b} + {4'b0, c};
                r.sum = s[3:0];
                r.carry = s[4];
            end
            2'b01: begin
                r.subon = 1'b1;
                r.diff = a - b;
                r.sgn = (a < b);
            end
            2'b10: begin
                r.mulon = 1'b1;
                r.pro = {4'b0, a} * {4'b0, b};
            end
            default: ;
        endcase
        return r;
    endfunction

    calc_seq_ctrl_if i1 ();
    calc_seq_ctrl_if i2 ();

    logic       busy1, busy2, cc1, cc2;
    logic [7:0] cnt1, cnt2;
    logic [1:0] cm1, cm2;
    logic [3:0] ca1, cb1, ca2, cb2;
    calc_t      c1, c2;

    always_comb begin
        c1 = calc_model(cm1, ca1, cb1, cc1);
        if (kill_mulon) c1.mulon = 1'b0;
        c2 = calc_model(cm2, ca2, cb2, cc2);
    end

    calc_seq_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(i1), .busy(busy1), .op_count(cnt1),
        .calc_mode(cm1), .calc_a(ca1), .calc_b(cb1), .calc_c(cc1),
        .calc_addon(c1.addon), .calc_subon(c1.subon), .calc_mulon(c1.mulon),
        .calc_sum(c1.sum), .calc_diff(c1.diff), .calc_carry(c1.carry),
        .calc_sgn(c1.sgn), .calc_pro(c1.pro)
    );

    calc_seq_ctrl #(.SETTLE_CYCLES(4), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(i2), .busy(busy2), .op_count(cnt2),
        .calc_mode(cm2), .calc_a(ca2), .calc_b(cb2), .calc_c(cc2),
        .calc_addon(c2.addon), .calc_subon(c2.subon), .calc_mulon(c2.mulon),
        .calc_sum(c2.sum), .calc_diff(c2.diff), .calc_carry(c2.carry),
        .calc_sgn(c2.sgn), .calc_pro(c2.pro)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one command on dut1 and wait (bounded) for rsp_valid; returns at a negedge.
    task automatic issue1(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic chain, output int cycles);
        @(negedge clk);
        i1.cmd_valid = 1'b1;
        i1.cmd_op = op;
        i1.cmd_a = a;
        i1.cmd_b = b;
        i1.cmd_cin = cin;
`ifdef CALC_SEQ_CHAIN_EN
        i1.cmd_chain = chain;
`endif
        check("cmd_ready_idle", 32'(i1.cmd_ready), 32'd1);
        @(negedge clk);
        i1.cmd_valid = 1'b0;
`ifdef CALC_SEQ_CHAIN_EN
        i1.cmd_chain = 1'b0;
`endif
        check("busy_after_accept", 32'(busy1), 32'd1);
        check("cmd_ready_busy", 32'(i1.cmd_ready), 32'd0);
        if (op != 2'b11) begin
            check("rsp_valid_early", 32'(i1.rsp_valid), 32'd0);
            check("drive_mode", 32'(cm1), 32'(op));
            if (!chain) check("drive_a", 32'(ca1), 32'(a));
            check("drive_b", 32'(cb1), 32'(b));
            check("drive_c", 32'(cc1), 32'((op == 2'b00) & cin));
        end
        cycles = 0;
        while (!i1.rsp_valid && cycles < 50) begin
            if (op == 2'b11) check("inv_mode_parked", 32'(cm1), 32'd3);
            @(negedge clk);
            cycles++;
        end
        if (!i1.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake1();
        i1.rsp_ready = 1'b1;
        @(negedge clk);
        i1.rsp_ready = 1'b0;
        check("cmd_ready_after_hs", 32'(i1.cmd_ready), 32'd1);
        check("rsp_valid_after_hs", 32'(i1.rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] a, b;
        logic       cin;
        logic [7:0] result;
        logic       flag, err;
    } vec_t;

    vec_t vecs[11];
    int   exp_cnt;
    int   cyc;
    logic ok;

    initial begin
        vecs[0]  = '{2'b00, 4'd9,  4'd8,  1'b1, 8'h02, 1'b1, 1'b0};
        vecs[1]  = '{2'b00, 4'd3,  4'd4,  1'b0, 8'h07, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 4'd15, 4'd0,  1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{2'b01, 4'd3,  4'd5,  1'b1, 8'h0E, 1'b1, 1'b0};
        vecs[4]  = '{2'b01, 4'd9,  4'd4,  1'b0, 8'h05, 1'b0, 1'b0};
        vecs[5]  = '{2'b01, 4'd7,  4'd7,  1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 4'd15, 4'd15, 1'b0, 8'hE1, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 4'd3,  4'd4,  1'b1, 8'h0C, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 4'd5,  4'd5,  1'b1, 8'h00, 1'b0, 1'b1};
        vecs[9]  = '{2'b10, 4'd0,  4'd9,  1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 4'd1,  4'd2,  1'b0, 8'h00, 1'b0, 1'b1};

        i1.cmd_valid = 0; i1.cmd_op = 0; i1.cmd_a = 0; i1.cmd_b = 0; i1.cmd_cin = 0; i1.rsp_ready = 0;
        i2.cmd_valid = 0; i2.cmd_op = 0; i2.cmd_a = 0; i2.cmd_b = 0; i2.cmd_cin = 0; i2.rsp_ready = 0;
`ifdef CALC_SEQ_CHAIN_EN
        i1.cmd_chain = 0;
        i2.cmd_chain = 0;
`endif

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(i1.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(i1.rsp_valid), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_op_count", 32'(cnt1), 32'd0);
        check("rst_calc_mode", 32'(cm1), 32'd3);
        check("rst_calc_ab", 32'({ca1, cb1, cc1}), 32'd0);
        check("rst_rsp_regs", 32'({i1.rsp_op, i1.rsp_result, i1.rsp_flag, i1.rsp_err}), 32'd0);
        rst_n = 1'b1;

        exp_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            issue1(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, cyc);
            if (vecs[i].op != 2'b11) check("latency_s1", 32'(cyc), 32'd1);
            else                     check("latency_inv", 32'(cyc <= 1), 32'd1);
            check("rsp_op", 32'(i1.rsp_op), 32'(vecs[i].op));
            check("rsp_result", 32'(i1.rsp_result), 32'(vecs[i].result));
            check("rsp_flag", 32'(i1.rsp_flag), 32'(vecs[i].flag));
            check("rsp_err", 32'(i1.rsp_err), 32'(vecs[i].err));
            check("resp_mode_parked", 32'(cm1), 32'd3);
            handshake1();
            if (!vecs[i].err) exp_cnt++;
            check("op_count", 32'(cnt1), 32'(exp_cnt));
        end

        // Backpressure: response held for 10 cycles must not move.
        issue1(2'b01, 4'd9, 4'd4, 1'b0, 1'b0, cyc);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!i1.rsp_valid || i1.rsp_result != 8'h05 || i1.rsp_op != 2'b01 ||
                i1.cmd_ready || !busy1 || cm1 != 2'b11)
                ok = 1'b0;
        end
        check("backpressure_frozen", 32'(ok), 32'd1);
        handshake1();
        exp_cnt++;
        check("op_count_bp", 32'(cnt1), 32'(exp_cnt));

        // Unit-enable mismatch: result still captured, err raised, count held.
        kill_mulon = 1'b1;
        issue1(2'b10, 4'd3, 4'd4, 1'b0, 1'b0, cyc);
        check("mulon_err", 32'(i1.rsp_err), 32'd1);
        check("mulon_result", 32'(i1.rsp_result), 32'h0C);
        handshake1();
        kill_mulon = 1'b0;
        check("op_count_err", 32'(cnt1), 32'(exp_cnt));

        // SETTLE_CYCLES=4 latency on the second instance.
        @(negedge clk);
        i2.cmd_valid = 1; i2.cmd_op = 2'b00; i2.cmd_a = 4'd9; i2.cmd_b = 4'd8; i2.cmd_cin = 1'b1;
        @(negedge clk);
        i2.cmd_valid = 0;
        cyc = 0;
        while (!i2.rsp_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("latency_s4", 32'(cyc), 32'd4);
        check("s4_result", 32'(i2.rsp_result), 32'h02);
        check("s4_flag", 32'(i2.rsp_flag), 32'd1);
        i2.rsp_ready = 1'b1;
        @(negedge clk);
        i2.rsp_ready = 1'b0;
        check("s4_cmd_ready", 32'(i2.cmd_ready), 32'd1);
        check("s4_op_count", 32'(cnt2), 32'd1);

        // Async reset in the middle of a mul DRIVE.
        @(negedge clk);
        i1.cmd_valid = 1; i1.cmd_op = 2'b10; i1.cmd_a = 4'd7; i1.cmd_b = 4'd6; i1.cmd_cin = 1'b0;
        @(negedge clk);
        i1.cmd_valid = 0;
        check("pre_rst_drive", 32'(cm1), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy1), 32'd0);
        check("rst_mid_mode", 32'(cm1), 32'd3);
        check("rst_mid_ab", 32'({ca1, cb1, cc1}), 32'd0);
        check("rst_mid_valid_ready", 32'({i1.rsp_valid, i1.cmd_ready}), 32'd1);
        check("rst_mid_count", 32'(cnt1), 32'd0);
        check("rst_mid_rsp", 32'({i1.rsp_op, i1.rsp_result, i1.rsp_flag, i1.rsp_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (i1.rsp_valid || busy1) ok = 1'b0;
        end
        check("no_rsp_after_rst", 32'(ok), 32'd1);
        exp_cnt = 0;

`ifdef CALC_SEQ_CHAIN_EN
        issue1(2'b10, 4'd3, 4'd4, 1'b0, 1'b0, cyc);
        check("chain_mul", 32'(i1.rsp_result), 32'h0C);
        handshake1();
        issue1(2'b00, 4'd0, 4'd1, 1'b0, 1'b1, cyc);
        check("chain_add", 32'(i1.rsp_result), 32'h0D);
        handshake1();
        exp_cnt += 2;
        check("chain_count", 32'(cnt1), 32'(exp_cnt));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
